cb_seed_gen: RTL and testbench

//  Runtime producer of cb_seed_t hash seeds for the counting-bloom-filter hashes. It replaces
//  the static seed table when seeds must change at boot or on rehash.
//  A 32-bit Galois LFSR is stepped under an FSM, each seed is emitted over a valid/ready

---
 rtl/cb_filter_pkg.sv | 26 ++
 rtl/cb_lfsr32.sv | 31 +++
 rtl/cb_seed_gen.sv | 128 ++++++++++++
 tb/tb_cb_seed_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cb_filter_pkg.sv
// rtl/cb_filter_pkg.sv - counting-bloom-filter shared seed type and LFSR constants
package cb_filter_pkg;

  typedef struct packed {
    logic [31:0] permute_seed;
    logic [31:0] xor_seed;
  } cb_seed_t;

  localparam logic [31:0] CbLfsrPoly    = 32'h0040_0007;
  localparam logic [31:0] CbLfsrDefault = 32'hCAFE_F00D;

  typedef enum logic [2:0] {
    SgIdle,
    SgWarm,
    SgPerm,
    SgXor,
    SgOut,
    SgDone
  } sg_state_e;

  // Galois step for x^32+x^22+x^2+x+1; a nonzero state never maps to zero
  function automatic logic [31:0] cb_lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? CbLfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/cb_lfsr32.sv
// rtl/cb_lfsr32.sv - 32-bit Galois LFSR with synchronous load and step enable
module cb_lfsr32
  import cb_filter_pkg::*;
#(
  parameter logic [31:0] InitState = CbLfsrDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_en,
  output logic [31:0] o_next
);

  logic [31:0] r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= InitState;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= cb_lfsr_next(r_state);
    end
  end

  assign o_next = cb_lfsr_next(r_state);

  a_state_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni) r_state != 32'h0);

endmodule

// File: rtl/cb_seed_gen.sv
// rtl/cb_seed_gen.sv - runtime hash-seed producer for the counting bloom filter
module cb_seed_gen
  import cb_filter_pkg::*;
#(
  parameter int unsigned NoHashes    = 3,
  parameter int unsigned WarmupSteps = 0,
  parameter logic [31:0] InitState   = CbLfsrDefault,
  localparam int unsigned IdxW       = (NoHashes > 1) ? $clog2(NoHashes) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     seed_i,
  output logic            busy_o,
  output logic            seed_valid_o,
  input  logic            seed_ready_i,
  output cb_seed_t        seed_o,
  output logic [IdxW-1:0] idx_o,
  output cb_seed_t        seeds_o [NoHashes],
  output logic            done_o
);

  localparam int unsigned     CntW    = (WarmupSteps > 1) ? $clog2(WarmupSteps) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((WarmupSteps > 0) ? WarmupSteps - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NoHashes - 1);

  sg_state_e       r_state;
  sg_state_e       w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_idx;
  logic [31:0]     r_perm;
  logic [31:0]     r_xor;
  cb_seed_t        r_seeds [NoHashes];

  logic            w_load;
  logic            w_step;
  logic            w_valid;
  logic            w_hs;
  logic [31:0]     w_load_val;
  logic [31:0]     w_lfsr_next;

  assign w_load_val = (seed_i == 32'h0) ? InitState : seed_i;
  assign w_hs       = w_valid && seed_ready_i;

  cb_lfsr32 #(
    .InitState(InitState)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (w_load),
    .i_seed (w_load_val),
    .i_en   (w_step),
    .o_next (w_lfsr_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SgIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SgIdle: if (start_i) w_state_nxt = (WarmupSteps > 0) ? SgWarm : SgPerm;
      SgWarm: if (r_cnt == CntLast) w_state_nxt = SgPerm;
      SgPerm: w_state_nxt = SgXor;
      SgXor:  w_state_nxt = SgOut;
      SgOut:  if (seed_ready_i) w_state_nxt = (r_idx == IdxLast) ? SgDone : SgPerm;
      SgDone: w_state_nxt = SgIdle;
      default: w_state_nxt = SgIdle;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_valid = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    case (r_state)
      SgIdle: begin
        busy_o = 1'b0;
        w_load = start_i;
      end
      SgWarm, SgPerm, SgXor: w_step = 1'b1;
      SgOut:  w_valid = 1'b1;
      SgDone: done_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
  end

  // The LFSR is frozen in OUT, so a stalled consumer sees the same seed and the next
  // PERM continues the sequence exactly where it left off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_perm <= 32'h0;
      r_xor  <= 32'h0;
      for (int i = 0; i < NoHashes; i++) r_seeds[i] <= '0;
    end else begin
      if (w_load) begin
        r_cnt <= '0;
        r_idx <= '0;
      end
      if (r_state == SgWarm) r_cnt <= r_cnt + 1'b1;
      if (r_state == SgPerm) r_perm <= w_lfsr_next;
      if (r_state == SgXor) r_xor <= w_lfsr_next;
      if (w_hs) begin
        r_seeds[r_idx] <= seed_o;
        if (r_idx != IdxLast) r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign seed_valid_o = w_valid;
  assign seed_o       = {r_perm, r_xor};
  assign idx_o        = r_idx;
  assign seeds_o      = r_seeds;

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_valid && !seed_ready_i) |=> ($stable(seed_o) && $stable(idx_o)));
  a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni) done_o |=> !done_o);

endmodule

// File: tb/tb_cb_seed_gen.sv
// tb/tb_cb_seed_gen.sv - directed-vector bench for cb_seed_gen
module tb_cb_seed_gen;
  import cb_filter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] seed_i = 32'h0;
  logic        ready0 = 1'b1;
  logic        ready1 = 1'b1;

  logic        busy0, valid0, done0, busy1, valid1, done1;
  cb_seed_t    seed0, seed1;
  logic [1:0]  idx0, idx1;
  cb_seed_t    seeds0 [3];
  cb_seed_t    seeds1 [3];

  int checks = 0;
  int passed = 0;

  cb_seed_t got_seed [8];
  int       got_idx  [8];
  int       n_got, first_valid, done_cyc, hold_cnt;
  cb_seed_t exp1 [3];

  always #5 clk = ~clk;

  cb_seed_gen #(.NoHashes(3), .WarmupSteps(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy0), .seed_valid_o(valid0), .seed_ready_i(ready0), .seed_o(seed0),
    .idx_o(idx0), .seeds_o(seeds0), .done_o(done0)
  );

  cb_seed_gen #(.NoHashes(3), .WarmupSteps(4)) dut_w (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy1), .seed_valid_o(valid1), .seed_ready_i(ready1), .seed_o(seed1),
    .idx_o(idx1), .seeds_o(seeds1), .done_o(done1)
  );

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    ref_step = s[31] ? ({s[30:0], 1'b0} ^ 32'h0040_0007) : {s[30:0], 1'b0};
  endfunction

  // Cycle 0 is the cycle in which start_i is high; cycle n is sampled at the n-th negedge after.
  task automatic run(input bit sel, input logic [31:0] seed, input int stall_idx,
                     input int stall_n, input cb_seed_t hold_exp, input int poke_cyc);
    int cyc, stalled;
    logic v, d, r;
    cb_seed_t sd;
    logic [1:0] ix;
    n_got = 0; first_valid = -1; done_cyc = -1; hold_cnt = 0; stalled = 0;
    @(negedge clk);
    seed_i = seed;
    start_i = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == poke_cyc);
      if (poke_cyc > 0) seed_i = 32'h1234_5678;
      v  = sel ? valid1 : valid0;
      d  = sel ? done1 : done0;
      sd = sel ? seed1 : seed0;
      ix = sel ? idx1 : idx0;
      if (v && first_valid < 0) first_valid = cyc;
      r = 1'b1;
      if (v && int'(ix) == stall_idx && stalled < stall_n) begin
        r = 1'b0;
        stalled++;
        if (sd === hold_exp) hold_cnt++;
      end
      if (sel) ready1 = r; else ready0 = r;
      if (v && r && n_got < 8) begin
        got_seed[n_got] = sd;
        got_idx[n_got] = int'(ix);
        n_got++;
      end
      if (d) done_cyc = cyc;
    end
    start_i = 1'b0;
    ready0 = 1'b1;
    ready1 = 1'b1;
    for (int k = 0; k < 40 && (busy0 || busy1); k++) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({busy0, valid0, done0, idx0} !== 5'b0) $display("FAIL reset_ctl0 got %b exp 00000", {busy0, valid0, done0, idx0}); else passed++;
    checks++; if (seed0 !== 64'h0) $display("FAIL reset_seed0 got %h exp 0", seed0); else passed++;
    checks++; if ({busy1, valid1, done1, idx1} !== 5'b0) $display("FAIL reset_ctl1 got %b exp 00000", {busy1, valid1, done1, idx1}); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (seeds0[i] !== 64'h0) $display("FAIL reset_seeds0[%0d] got %h exp 0", i, seeds0[i]); else passed++;
    end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run(1'b0, 32'h1, -1, 0, '0, 0);
    checks++; if (n_got !== 3) $display("FAIL t1_count got %0d exp 3", n_got); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_seed[i] !== exp1[i]) $display("FAIL t1_seed%0d got %h exp %h", i, got_seed[i], exp1[i]); else passed++;
      checks++; if (got_idx[i] !== i) $display("FAIL t1_idx%0d got %0d exp %0d", i, got_idx[i], i); else passed++;
      checks++; if (seeds0[i] !== exp1[i]) $display("FAIL t1_array%0d got %h exp %h", i, seeds0[i], exp1[i]); else passed++;
    end
    checks++; if (first_valid - 1 !== 2) $display("FAIL t1_latency got %0d exp 2", first_valid - 1); else passed++;
    checks++; if (done_cyc + 1 !== 11) $display("FAIL t1_run_len got %0d exp 11", done_cyc + 1); else passed++;
  endtask

  task automatic test_high_bit();
    run(1'b0, 32'h8000_0000, -1, 0, '0, 0);
    checks++; if (got_seed[0] !== {32'h0040_0007, 32'h0080_000E})
      $display("FAIL t2_seed0 got %h exp %h", got_seed[0], {32'h0040_0007, 32'h0080_000E}); else passed++;
    checks++; if (n_got !== 3) $display("FAIL t2_count got %0d exp 3", n_got); else passed++;
  endtask

  task automatic test_stall();
    run(1'b0, 32'h1, 1, 5, {32'd8, 32'd16}, 0);
    checks++; if (hold_cnt !== 5) $display("FAIL t3_hold got %0d exp 5", hold_cnt); else passed++;
    checks++; if (n_got !== 3) $display("FAIL t3_count got %0d exp 3", n_got); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_seed[i] !== exp1[i]) $display("FAIL t3_seed%0d got %h exp %h", i, got_seed[i], exp1[i]); else passed++;
      checks++; if (got_idx[i] !== i) $display("FAIL t3_idx%0d got %0d exp %0d", i, got_idx[i], i); else passed++;
    end
    checks++; if (done_cyc + 1 !== 16) $display("FAIL t3_run_len got %0d exp 16", done_cyc + 1); else passed++;
  endtask

  task automatic test_warmup();
    cb_seed_t exp4 [3];
    exp4[0] = {32'd32, 32'd64};
    exp4[1] = {32'd128, 32'd256};
    exp4[2] = {32'd512, 32'd1024};
    run(1'b1, 32'h1, -1, 0, '0, 0);
    checks++; if (first_valid - 1 !== 6) $display("FAIL t4_latency got %0d exp 6", first_valid - 1); else passed++;
    checks++; if (done_cyc + 1 !== 15) $display("FAIL t4_run_len got %0d exp 15", done_cyc + 1); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_seed[i] !== exp4[i]) $display("FAIL t4_seed%0d got %h exp %h", i, got_seed[i], exp4[i]); else passed++;
      checks++; if (seeds1[i] !== exp4[i]) $display("FAIL t4_array%0d got %h exp %h", i, seeds1[i], exp4[i]); else passed++;
    end
  endtask

  task automatic test_default_seed();
    cb_seed_t exp5 [3];
    logic [31:0] s, p, x;
    s = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      p = ref_step(s);
      x = ref_step(p);
      exp5[i] = {p, x};
      s = x;
    end
    run(1'b0, 32'h0, -1, 0, '0, 5);
    checks++; if (n_got !== 3) $display("FAIL t5_count got %0d exp 3", n_got); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_seed[i] !== exp5[i]) $display("FAIL t5_seed%0d got %h exp %h", i, got_seed[i], exp5[i]); else passed++;
    end
    checks++; if (done_cyc + 1 !== 11) $display("FAIL t5_run_len got %0d exp 11", done_cyc + 1); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL t5_no_restart got %b exp 0", busy0); else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit found;
    found = 1'b0;
    @(negedge clk);
    seed_i = 32'h1;
    start_i = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (valid0 && idx0 == 2'd1) begin
        ready0 = 1'b0;
        found = 1'b1;
      end
    end
    checks++; if (found !== 1'b1) $display("FAIL t6_reach_out1 got %b exp 1", found); else passed++;
    checks++; if (seeds0[0] !== exp1[0]) $display("FAIL t6_pre_array0 got %h exp %h", seeds0[0], exp1[0]); else passed++;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if ({busy0, valid0, done0, idx0} !== 5'b0) $display("FAIL t6_ctl got %b exp 00000", {busy0, valid0, done0, idx0}); else passed++;
    checks++; if (seed0 !== 64'h0) $display("FAIL t6_seed got %h exp 0", seed0); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (seeds0[i] !== 64'h0) $display("FAIL t6_array%0d got %h exp 0", i, seeds0[i]); else passed++;
    end
    @(negedge clk);
    rst_ni = 1'b1;
    ready0 = 1'b1;
    @(negedge clk);
    test_basic();
  endtask

  initial begin
    exp1[0] = {32'd2, 32'd4};
    exp1[1] = {32'd8, 32'd16};
    exp1[2] = {32'd32, 32'd64};
    test_reset();
    test_basic();
    test_high_bit();
    test_stall();
    test_warmup();
    test_default_seed();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
